// File: rtl/rd_data_chk_if.sv
// Bus bundle between the DDR2 read-data path and the read-back checker.
// The master modport drives read data and control; the slave modport is the checker.
interface rd_data_chk_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              phy_init_done;
    logic              restart;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [CNT_W-1:0]  word_count;
    logic [CNT_W-1:0]  err_count;
    logic              first_err_vld;
    logic [CNT_W-1:0]  first_err_idx;
    logic [DATA_W-1:0] first_err_exp;
    logic [DATA_W-1:0] first_err_got;

    modport master (
        output phy_init_done, restart, rd_data_valid, rd_data,
        input  busy, done, pass, timeout, word_count, err_count,
        input  first_err_vld, first_err_idx, first_err_exp, first_err_got
    );

    modport slave (
        input  phy_init_done, restart, rd_data_valid, rd_data,
        output busy, done, pass, timeout, word_count, err_count,
        output first_err_vld, first_err_idx, first_err_exp, first_err_got
    );
endinterface

// File: rtl/rd_data_chk.sv
// Read-back checker: compares returned read words against an incrementing pattern,
// counts words/errors, captures the first mismatch and flags a stalled stream.
module rd_data_chk #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_WORDS = 2048,
    parameter logic [DATA_W-1:0] SEED      = '0,
    parameter int unsigned       TIMEOUT   = 4096,
    parameter int unsigned       CNT_W     = 16
) (
    input logic           clk,
    input logic           reset_n,
    rd_data_chk_if.slave  bus_io
);

    localparam int unsigned       WD_W     = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_WORDS);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StArmed = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              fe_vld_q, fe_vld_d;
    logic [CNT_W-1:0]  fe_idx_q, fe_idx_d;
    logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_W-1:0] fe_got_q, fe_got_d;
    logic              timeout_q, timeout_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clr;

    // restart is honoured everywhere except the single post-reset IDLE cycle
    assign clr = bus_io.restart && (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        wd_d       = wd_q;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        fe_vld_d   = fe_vld_q;
        fe_idx_d   = fe_idx_q;
        fe_exp_d   = fe_exp_q;
        fe_got_d   = fe_got_q;
        timeout_d  = timeout_q;

        case (state_q)
            StIdle:  state_d = StArmed;
            StArmed: if (bus_io.phy_init_done) state_d = StCheck;
            StCheck: begin
                if (bus_io.rd_data_valid) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    exp_d      = exp_q + 1'b1;
                    wd_d       = '0;
                    if (bus_io.rd_data != exp_q) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        if (!fe_vld_q) begin
                            fe_vld_d = 1'b1;
                            fe_idx_d = word_cnt_q;
                            fe_exp_d = exp_q;
                            fe_got_d = bus_io.rd_data;
                        end
                    end
                    if (word_cnt_d == LAST_CNT) state_d = StDone;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_LAST) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase

        if (clr) begin
            state_d    = StArmed;
            exp_d      = SEED;
            wd_d       = '0;
            word_cnt_d = '0;
            err_cnt_d  = '0;
            fe_vld_d   = 1'b0;
            fe_idx_d   = '0;
            fe_exp_d   = '0;
            fe_got_d   = '0;
            timeout_d  = 1'b0;
        end

        busy_d = (state_d == StCheck);
        done_d = (state_d == StDone);
        // Uses next-state error count so the final word's compare is included
        pass_d = done_d && (err_cnt_d == '0) && !timeout_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            exp_q      <= SEED;
            wd_q       <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            fe_vld_q   <= 1'b0;
            fe_idx_q   <= '0;
            fe_exp_q   <= '0;
            fe_got_q   <= '0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            wd_q       <= wd_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fe_vld_q   <= fe_vld_d;
            fe_idx_q   <= fe_idx_d;
            fe_exp_q   <= fe_exp_d;
            fe_got_q   <= fe_got_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus_io.busy          = busy_q;
    assign bus_io.done          = done_q;
    assign bus_io.pass          = pass_q;
    assign bus_io.timeout       = timeout_q;
    assign bus_io.word_count    = word_cnt_q;
    assign bus_io.err_count     = err_cnt_q;
    assign bus_io.first_err_vld = fe_vld_q;
    assign bus_io.first_err_idx = fe_idx_q;
    assign bus_io.first_err_exp = fe_exp_q;
    assign bus_io.first_err_got = fe_got_q;

endmodule
